// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: turns valid/ready command, write-data and response streams into pipelined AHB-Lite SINGLE/INCR transfers
module ahb_lite_cmd_master #(
    parameter int HADDR_SIZE = 8,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [HADDR_SIZE-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    input  logic [3:0]            cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [HDATA_SIZE-1:0] wr_data,
    output logic                  rsp_valid,
    output logic [HDATA_SIZE-1:0] rsp_data,
    output logic                  rsp_err,
    output logic                  done,
    output logic                  done_err,
    output logic                  HSEL,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HREADY,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADYOUT,
    input  logic                  HRESP
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR} state_t;
    localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;
    state_t                r_state;
    logic                  r_hsel, r_hwrite, r_dp, r_first, r_done, r_done_err;
    logic [HADDR_SIZE-1:0] r_haddr, r_next;
    logic [HDATA_SIZE-1:0] r_hwdata, r_wbuf;
    logic [2:0]            r_hsize, r_hburst;
    logic [1:0]            r_htrans;
    logic [4:0]            r_left, r_drain;
    logic                  w_accept, w_issue, w_err1;
    assign cmd_ready = (r_state == S_IDLE) && !HRESET;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_err1    = r_dp && !HREADYOUT && HRESP && (r_state == S_ADDR || r_state == S_LAST);
    assign w_issue   = (r_state == S_ADDR) && HREADYOUT && (r_left != 5'd0) && (!r_hwrite || wr_valid);
    assign wr_ready  = ((r_state == S_ADDR) && r_hwrite && HREADYOUT && (r_left != 5'd0)) ||
                       ((r_state == S_ERR) && (r_drain != 5'd0));
    assign rsp_valid = r_dp && HREADYOUT;
    assign rsp_err   = rsp_valid && HRESP;
    assign rsp_data  = (rsp_valid && !r_hwrite) ? HRDATA : '0;
    assign done      = r_done;
    assign done_err  = r_done_err;
    assign HSEL      = r_hsel;
    assign HADDR     = r_haddr;
    assign HWDATA    = r_hwdata;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = r_hburst;
    assign HPROT     = 4'b0011;
    assign HTRANS    = r_htrans;
    assign HREADY    = HREADYOUT;
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= S_IDLE;
            r_hsel     <= 1'b0;
            r_hwrite   <= 1'b0;
            r_dp       <= 1'b0;
            r_first    <= 1'b0;
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            r_haddr    <= '0;
            r_next     <= '0;
            r_hwdata   <= '0;
            r_wbuf     <= '0;
            r_hsize    <= 3'd0;
            r_hburst   <= 3'd0;
            r_htrans   <= T_IDLE;
            r_left     <= 5'd0;
            r_drain    <= 5'd0;
        end else begin
            r_done     <= 1'b0;
            r_done_err <= 1'b0;
            if (w_err1) begin
                // first error cycle: cancel the pending address phase, drain unissued write words
                r_htrans <= T_IDLE;
                r_hsel   <= 1'b0;
                r_drain  <= r_hwrite ? r_left : 5'd0;
                r_state  <= S_ERR;
            end else begin
                if (HREADYOUT) begin
                    r_dp <= r_htrans[1];
                    if (r_htrans[1] && r_hwrite)
                        r_hwdata <= r_wbuf;
                end
                if (w_accept) begin
                    r_next   <= cmd_addr;
                    r_hwrite <= cmd_write;
                    r_hsize  <= cmd_size;
                    r_hburst <= (cmd_len == 4'd0) ? 3'b000 : 3'b001;
                    r_left   <= {1'b0, cmd_len} + 5'd1;
                    r_first  <= 1'b1;
                    r_state  <= S_ADDR;
                end else if (w_issue) begin
                    r_htrans <= r_first ? T_NONSEQ : T_SEQ;
                    r_hsel   <= 1'b1;
                    r_haddr  <= r_next;
                    r_next   <= r_next + (HADDR_SIZE'(1) << r_hsize);
                    r_first  <= 1'b0;
                    r_left   <= r_left - 5'd1;
                    if (r_hwrite)
                        r_wbuf <= wr_data;
                    if (r_left == 5'd1)
                        r_state <= S_LAST;
                end else if (HREADYOUT && r_state == S_ADDR) begin
                    // write data not ready: idle before the first beat, BUSY mid-burst
                    r_htrans <= r_first ? T_IDLE : T_BUSY;
                    r_hsel   <= !r_first;
                end else if (HREADYOUT && r_state == S_LAST) begin
                    r_htrans <= T_IDLE;
                    r_hsel   <= 1'b0;
                    if (r_dp && !r_htrans[1]) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end else if (r_state == S_ERR) begin
                    if (wr_valid && r_drain != 5'd0)
                        r_drain <= r_drain - 5'd1;
                    if (!r_dp && r_drain == 5'd0) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_done_err <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb_ahb_lite_cmd_master: scoreboard bench with a behavioural SRAM slave that can inject wait states and errors
module tb_ahb_lite_cmd_master;
    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, wr_valid = 1'b0;
    logic [7:0]  cmd_addr = 8'h0;
    logic [2:0]  cmd_size = 3'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic [31:0] wr_data = 32'h0;
    logic        cmd_ready, wr_ready, rsp_valid, rsp_err, done, done_err;
    logic [31:0] rsp_data, HWDATA, HRDATA;
    logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
    logic [7:0]  HADDR;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    always #5 HCLK = ~HCLK;
    ahb_lite_cmd_master #(.HADDR_SIZE(8), .HDATA_SIZE(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .done(done), .done_err(done_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
        .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
    );
    int n_tests = 0, n_fail = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // slave model: word memory, wait/error injection keyed on the global address-phase count
    logic [31:0] mem [64] = '{default: 32'h0};
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    logic        s_act = 1'b0, s_wr = 1'b0, s_err = 1'b0, s_eph = 1'b0;
    logic [7:0]  s_addr = 8'h0;
    int          s_wcnt = 0, acc_cnt = 0, wait_at = -1, wait_n = 2, err_at = -1;
    assign HREADYOUT = !s_act || (s_wcnt == 0 && (!s_err || s_eph));
    assign HRESP     = s_act && s_err && s_wcnt == 0;
    assign HRDATA    = (s_act && !s_wr) ? mem[s_addr[7:2]] : 32'h0;
    always @(posedge HCLK) begin
        if (HRESET) begin
            s_act <= 1'b0; s_wcnt <= 0; s_err <= 1'b0; s_eph <= 1'b0;
        end else if (HREADYOUT) begin
            if (s_act && s_wr && !s_err) mem[s_addr[7:2]] <= HWDATA;
            s_act <= HSEL && HTRANS[1];
            s_eph <= 1'b0;
            if (HSEL && HTRANS[1]) begin
                s_addr  <= HADDR;
                s_wr    <= HWRITE;
                s_wcnt  <= (acc_cnt == wait_at) ? wait_n : 0;
                s_err   <= (acc_cnt == err_at);
                acc_cnt <= acc_cnt + 1;
            end else begin
                s_err <= 1'b0; s_wcnt <= 0;
            end
        end else if (s_wcnt > 0) s_wcnt <= s_wcnt - 1;
        else s_eph <= 1'b1;
    end
    // scoreboard and bus monitors, sampled on the falling edge
    logic [32:0] rsp_q[$];
    logic [16:0] addr_q[$];
    logic        done_q[$];
    int          done_cnt = 0, busy_cnt = 0;
    logic [42:0] prev_bus = '0;
    logic        prev_wait = 1'b0;
    always @(negedge HCLK) begin
        prev_bus  <= {HSEL, HTRANS, HADDR, HWDATA};
        prev_wait <= !HREADYOUT && !HRESP && !HRESET;
        if (!HRESET) begin
            if (prev_wait) check("wait_hold", {HSEL, HTRANS, HADDR, HWDATA}, prev_bus);
            if (HTRANS == 2'b01) begin
                busy_cnt <= busy_cnt + 1;
                check("busy_haddr", HADDR, prev_bus[39:32]);
            end
            if (HSEL && HTRANS[1] && HREADYOUT) begin
                if (addr_q.size() == 0) check("addr_unexp", HTRANS, 2'b00);
                else check("addr_phase", {HWRITE, HSIZE, HBURST, HTRANS, HADDR}, addr_q.pop_front());
            end
            if (rsp_valid) begin
                check("rsp_hready", HREADYOUT, 1'b1);
                if (rsp_q.size() == 0) check("rsp_unexp", rsp_valid, 1'b0);
                else check("rsp", {rsp_err, rsp_data}, rsp_q.pop_front());
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                if (done_q.size() == 0) check("done_unexp", done, 1'b0);
                else check("done_err", done_err, done_q.pop_front());
            end
        end
    end
    task automatic chk_rst(input string tag);
        check({tag, "_bus"}, {HTRANS, HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT},
              {2'b00, 1'b0, 8'h00, 32'h0, 1'b0, 3'd0, 3'd0, 4'b0011});
        check({tag, "_out"}, {rsp_valid, rsp_err, rsp_data, done, done_err, wr_ready}, 37'h0);
    endtask
    task automatic issue(input logic [7:0] a, input logic w, input int len);
        int n = 0;
        while (!cmd_ready && n < 200) begin @(posedge HCLK); #1; n++; end
        check("cmd_ready", cmd_ready, 1'b1);
        cmd_addr = a; cmd_write = w; cmd_size = 3'd2; cmd_len = len[3:0]; cmd_valid = 1'b1;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
    endtask
    task automatic feed(input logic [31:0] d, input int gap);
        int n = 0;
        logic hs = 1'b0;
        wr_valid = 1'b0;
        repeat (gap) begin @(posedge HCLK); #1; end
        wr_valid = 1'b1; wr_data = d;
        while (!hs && n < 200) begin
            @(negedge HCLK); hs = wr_ready;
            @(posedge HCLK); #1; n++;
        end
        check("wr_hs", hs, 1'b1);
    endtask
    task automatic wait_done();
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 300) begin @(posedge HCLK); n++; end
        #1;
        check("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask
    task automatic push_exp(input logic [7:0] a, input logic w, input int len, input logic [31:0] base,
                            input int err_rel);
        int last = (err_rel >= 0) ? err_rel : len;
        for (int i = 0; i <= last; i++) begin
            logic [7:0] ba = a + 8'(4 * i);
            addr_q.push_back({w, 3'd2, (len == 0) ? 3'd0 : 3'd1, (i == 0) ? 2'b10 : 2'b11, ba});
            rsp_q.push_back({i == err_rel, w ? 32'h0 : ref_mem[ba[7:2]]});
            if (w && i != err_rel) ref_mem[ba[7:2]] = base + 32'(i);
        end
    endtask
    task automatic run(input logic [7:0] a, input logic w, input int len, input logic [31:0] base,
                       input int err_rel, input int wait_rel, input int gap_beat, input int gap);
        err_at  = (err_rel >= 0) ? acc_cnt + err_rel : -1;
        wait_at = (wait_rel >= 0) ? acc_cnt + wait_rel : -1;
        push_exp(a, w, len, base, err_rel);
        done_q.push_back(err_rel >= 0);
        issue(a, w, len);
        if (w) for (int i = 0; i <= len; i++) feed(base + 32'(i), (i == gap_beat) ? gap : 0);
        wr_valid = 1'b0;
        wait_done();
        check("rsp_left", 64'(rsp_q.size()), 64'd0);
        check("addr_left", 64'(addr_q.size()), 64'd0);
        check("done_left", 64'(done_q.size()), 64'd0);
    endtask
    initial begin
        int b0, d0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        chk_rst("rst0");
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        run(8'h10, 1'b1, 0, 32'hDEADBEEF, -1, -1, -1, 0);
        run(8'h10, 1'b0, 0, 32'h0, -1, -1, -1, 0);
        run(8'hF8, 1'b1, 3, 32'h1, -1, -1, -1, 0);
        run(8'hF8, 1'b0, 3, 32'h0, -1, -1, -1, 0);
        b0 = busy_cnt;
        run(8'h08, 1'b1, 2, 32'h100, -1, -1, 1, 2);
        check("busy_cycles", 64'(busy_cnt - b0), 64'd2);
        run(8'h08, 1'b0, 2, 32'h0, -1, -1, -1, 0);
        run(8'hF8, 1'b0, 1, 32'h0, -1, 0, -1, 0);
        run(8'h40, 1'b1, 3, 32'hE0000001, 1, -1, -1, 0);
        run(8'h40, 1'b0, 3, 32'h0, -1, -1, -1, 0);
        // reset in the middle of an 8-beat read
        err_at = -1; wait_at = -1;
        push_exp(8'hF8, 1'b0, 7, 32'h0, -1);
        issue(8'hF8, 1'b0, 7);
        repeat (3) begin @(posedge HCLK); #1; end
        HRESET = 1'b1;
        @(negedge HCLK);
        check("rst_mid_cmd_ready", cmd_ready, 1'b0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rsp_q.delete(); addr_q.delete(); done_q.delete();
        d0 = done_cnt;
        @(negedge HCLK);
        chk_rst("rst_mid");
        repeat (5) @(posedge HCLK);
        #1;
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        run(8'h08, 1'b0, 2, 32'h0, -1, -1, -1, 0);
        run(8'h20, 1'b1, 1, 32'h55AA0000, -1, 1, -1, 0);
        run(8'h20, 1'b0, 1, 32'h0, -1, -1, -1, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/ahb_lite_cmd_master.md
Name: ahb_lite_cmd_master

Overview:
- Command-driven AHB-Lite master that sits directly upstream of the single-port SRAM slave and drives its full AHB-Lite slave interface.
- Converts simple valid/ready command, write-data and response streams into pipelined AHB-Lite SINGLE/INCR transfers.
- Handles slave wait states and the two-cycle error response.
- Used as the stimulus engine in front of the SRAM in system sims and in the SoC fabric.

Parameters:
- HADDR_SIZE, 8, width of HADDR and cmd_addr.
- HDATA_SIZE, 32, width of HWDATA, HRDATA, wr_data and rsp_data.

Ports:
- HCLK  in  1  single clock; all logic on its rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  HADDR_SIZE  start byte address.
- cmd_write  in  1  1=write, 0=read.
- cmd_size  in  3  HSIZE value (0..2 legal for 32-bit).
- cmd_len  in  4  beats-1 (0..15).
- wr_valid / wr_ready  in / out  1 / 1  write-data stream, one word per write beat.
- wr_data  in  HDATA_SIZE  write word.
- rsp_valid  out  1  one pulse per completed beat; no backpressure.
- rsp_data  out  HDATA_SIZE  HRDATA for reads, 0 for writes.
- rsp_err  out  1  beat completed with ERROR.
- done / done_err  out  1 / 1  one-cycle pulse at command end; done_err=1 if aborted.
- HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS  out  1, HADDR_SIZE, HDATA_SIZE, 1, 3, 3, 4, 2  AHB-Lite master outputs, all registered.
- HREADY  out  1  = HREADYOUT (combinational pass-through, single-slave system).
- HRDATA, HREADYOUT, HRESP  in  HDATA_SIZE, 1, 1  slave responses.

Behaviour:
- Reset (HRESET=1 at an edge) gives on the next cycle:
  - HTRANS=IDLE(00), HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=4'b0011.
  - rsp_valid=0, rsp_err=0, rsp_data=0, done=0, done_err=0, wr_ready=0.
  - State=IDLE; all in-flight beats dropped with no rsp and no done.
  - cmd_ready=0 while HRESET=1.
- States:
  - IDLE: cmd_ready=1. Accept captures addr/write/size/len and sets beat counters → ADDR.
  - ADDR: address phases being issued; data phases overlap.
  - LAST: all address phases issued, final data phase pending.
  - ERR: second error cycle / write-data drain.
  - Completion of last data phase or ERR exit → IDLE with done pulse.
- Address-phase register updates only on edges where HREADYOUT=1 (or when the bus is idle). At each update, if beats remain:
  - Read, or write with wr_valid=1: issue beat. HTRANS=NONSEQ on first beat, SEQ otherwise. HSEL=1. For writes assert wr_ready that cycle and latch wr_data.
  - Write without wr_valid: first beat → HTRANS=IDLE, HSEL=0 (retry next cycle); later beats → HTRANS=BUSY, HADDR/controls unchanged.
- HBURST = SINGLE(000) if cmd_len=0, else INCR(001). HPROT constant 4'b0011.
- HADDR for the next beat = HADDR + (1<<HSIZE), modulo 2^HADDR_SIZE (wraps silently).
- Data phase: latched write word moves to HWDATA on the edge its address phase is accepted (HREADYOUT=1 with NONSEQ/SEQ). HWDATA is held stable through wait states.
- Beat completes in the cycle HREADYOUT=1 with an active data phase: rsp_valid=1 that same cycle (combinational from the data-phase flag), rsp_data=HRDATA for reads, rsp_err=HRESP.
- Wait states: HREADYOUT=0 with HRESP=0 freezes all AHB outputs, counters and wr_ready.
- Error (HREADYOUT=0 && HRESP=1 in data phase, first error cycle):
  - Next edge: HTRANS←IDLE, HSEL←0. The pending address phase is cancelled; its beat is not reissued.
  - Enter ERR. The second cycle (HREADYOUT=1, HRESP=1) yields rsp_valid=1, rsp_err=1.
  - Remaining, never-issued write beats are drained: wr_ready=1 until the remaining wr words are consumed, no rsp for them.
  - Then done=1, done_err=1 → IDLE.
- Normal end: done=1, done_err=0 in the cycle after the final beat's rsp. cmd_ready returns to 1 that same cycle; there is no overlap between commands.
- Beat count: exactly cmd_len+1 rsp pulses unless aborted.

Test Plan:
- SRAM slave; write cmd addr 0x10, size 2, len 0, wr_data 0xDEADBEEF, then read 0x10 → HTRANS NONSEQ/HBURST SINGLE each; read rsp_data=0xDEADBEEF, rsp_err=0, done twice.
- 4-beat INCR word write from 0xF8, data 1..4, then 4-beat read from 0xF8 → HADDR F8,FC,00,04, HTRANS NONSEQ,SEQ,SEQ,SEQ; read rsp 1,2,3,4.
- 3-beat write with wr_valid low for 2 cycles before beat 2 → HTRANS shows two BUSY cycles with HADDR frozen; memory correct, 3 rsp pulses.
- Bench slave inserts 2 wait states on beat 1 of a 2-beat read → HADDR/HTRANS frozen during waits, rsp_valid only when HREADYOUT=1, data matches.
- Bench slave returns ERROR on beat 2 of a 4-beat write → HTRANS=IDLE in second error cycle, one rsp_err=1, remaining write word drained, done_err=1, beats 3-4 never on bus.
- HRESET asserted mid 8-beat read → next cycle all outputs at reset values, no done; a new command afterwards runs normally.
